// File: rtl/usb_link_ctrl.sv
// usb_link_ctrl: USB link-state controller between the PHY and the packet engines.
//   Decodes the filtered line state into bus reset, suspend and host-resume events,
//   and owns the PHY transmit pins: packet drive in ACTIVE, forced K during remote
//   wakeup, idle otherwise. All durations are in clk cycles.
// Ports:
//   clk, rst                      clock; asynchronous active-high reset
//   phy_rx_dp/dn, phy_rx_chg      filtered line levels and edge indication
//   phy_tx_dp/dn/en               drive to the PHY (combinational mux from state)
//   pkt_tx_dp/dn/en               packet transmitter drive
//   rwk_ena, rwk_req              remote wakeup enable / single-cycle request
//   line_state                    registered {dp,dn}
//   bus_reset, suspend, rwk_busy  state levels
//   bus_reset_stb, resume_stb     one-cycle pulses on state entry
module usb_link_ctrl #(
  parameter int RST_TICKS      = 120,
  parameter int SUSP_TICKS     = 144000,
  parameter int RWK_IDLE_TICKS = 240000,
  parameter int RWK_TICKS      = 96000,
  parameter int CNT_W          = 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       phy_rx_dp,
  input  logic       phy_rx_dn,
  input  logic       phy_rx_chg,
  output logic       phy_tx_dp,
  output logic       phy_tx_dn,
  output logic       phy_tx_en,
  input  logic       pkt_tx_dp,
  input  logic       pkt_tx_dn,
  input  logic       pkt_tx_en,
  input  logic       rwk_ena,
  input  logic       rwk_req,
  output logic [1:0] line_state,
  output logic       bus_reset,
  output logic       bus_reset_stb,
  output logic       suspend,
  output logic       resume_stb,
  output logic       rwk_busy
);

  typedef enum logic [2:0] {
    S_ACTIVE, S_RESET, S_SUSPEND, S_RWK_PEND, S_RWK
  } state_t;

  localparam logic [1:0] LS_SE0 = 2'b00;
  localparam logic [1:0] LS_K   = 2'b01;
  localparam logic [1:0] LS_J   = 2'b10;

  localparam logic [CNT_W-1:0] RST_LIM  = CNT_W'(RST_TICKS - 1);
  localparam logic [CNT_W-1:0] SUSP_LIM = CNT_W'(SUSP_TICKS - 1);
  localparam logic [CNT_W-1:0] IDLE_LIM = CNT_W'(RWK_IDLE_TICKS - 1);
  localparam logic [CNT_W-1:0] RWK_LIM  = CNT_W'(RWK_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state_q, state_d;
  logic [1:0]       ls_q;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             rst_stb_q, rst_stb_d;
  logic             res_stb_q, res_stb_d;
  logic             keep_cnt;
  logic [1:0]       rx_s;

  assign rx_s    = {phy_rx_dp, phy_rx_dn};
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_ACTIVE: begin
        if (ls_q == LS_SE0 && cnt_q == RST_LIM)     state_d = S_RESET;
        else if (ls_q == LS_J && cnt_q == SUSP_LIM) state_d = S_SUSPEND;
      end
      S_RESET: if (ls_q != LS_SE0) state_d = S_ACTIVE;
      S_SUSPEND, S_RWK_PEND: begin
        // K (host resume) wins over everything, then bus reset, then wakeup logic
        if (ls_q == LS_K)                            state_d = S_ACTIVE;
        else if (ls_q == LS_SE0 && cnt_q == RST_LIM) state_d = S_RESET;
        else if (state_q == S_SUSPEND) begin
          if (rwk_req && rwk_ena)                    state_d = S_RWK_PEND;
        end
        else if (!rwk_ena)                           state_d = S_SUSPEND;
        else if (ls_q == LS_J && cnt_q >= IDLE_LIM)  state_d = S_RWK;
      end
      S_RWK: if (cnt_q == RWK_LIM) state_d = S_ACTIVE;
      default: state_d = S_ACTIVE;
    endcase
  end

  // Idle time accumulated in SUSPEND carries into RWK_PEND; in RWK the counter
  // times our own K drive and ignores whatever the line shows.
  always_comb begin
    keep_cnt = (state_d == state_q) || (state_q == S_SUSPEND && state_d == S_RWK_PEND);
    cnt_d    = '0;
    if (keep_cnt) begin
      if (state_q == S_RWK)                      cnt_d = cnt_inc;
      else if (rx_s != ls_q || phy_rx_chg)       cnt_d = '0;
      else                                       cnt_d = cnt_inc;
    end
  end

  always_comb begin
    rst_stb_d = (state_d == S_RESET) && (state_q != S_RESET);
    res_stb_d = (state_d == S_ACTIVE) &&
                (state_q == S_SUSPEND || state_q == S_RWK_PEND || state_q == S_RWK);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_ACTIVE;
      ls_q      <= 2'b00;
      cnt_q     <= '0;
      rst_stb_q <= 1'b0;
      res_stb_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ls_q      <= rx_s;
      cnt_q     <= cnt_d;
      rst_stb_q <= rst_stb_d;
      res_stb_q <= res_stb_d;
    end
  end

  always_comb begin
    phy_tx_dp = 1'b0;
    phy_tx_dn = 1'b0;
    phy_tx_en = 1'b0;
    if (state_q == S_ACTIVE) begin
      phy_tx_dp = pkt_tx_dp;
      phy_tx_dn = pkt_tx_dn;
      phy_tx_en = pkt_tx_en;
    end else if (state_q == S_RWK) begin
      phy_tx_dn = 1'b1;
      phy_tx_en = 1'b1;
    end
  end

  assign line_state    = ls_q;
  assign bus_reset     = (state_q == S_RESET);
  assign bus_reset_stb = rst_stb_q;
  assign suspend       = (state_q == S_SUSPEND) || (state_q == S_RWK_PEND);
  assign resume_stb    = res_stb_q;
  assign rwk_busy      = (state_q == S_RWK_PEND) || (state_q == S_RWK);

endmodule

// File: tb/tb_usb_link_ctrl.sv
module tb_usb_link_ctrl;
  localparam int RT = 8, ST = 64, IT = 32, WT = 16, CW = 18;

  logic clk = 0, rst = 1;
  logic dp = 1, dn = 0, chg = 0;
  logic pdp = 0, pdn = 0, pen = 0;
  logic ena = 0, req = 0;
  logic tdp, tdn, ten;
  logic [1:0] ls;
  logic br, brs, sus, res, busy;
  int total = 0, bad = 0;

  usb_link_ctrl #(.RST_TICKS(RT), .SUSP_TICKS(ST), .RWK_IDLE_TICKS(IT),
                  .RWK_TICKS(WT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .phy_rx_dp(dp), .phy_rx_dn(dn), .phy_rx_chg(chg),
    .phy_tx_dp(tdp), .phy_tx_dn(tdn), .phy_tx_en(ten),
    .pkt_tx_dp(pdp), .pkt_tx_dn(pdn), .pkt_tx_en(pen),
    .rwk_ena(ena), .rwk_req(req), .line_state(ls),
    .bus_reset(br), .bus_reset_stb(brs), .suspend(sus),
    .resume_stb(res), .rwk_busy(busy));

  always #5 clk = ~clk;

  // Reference model: tracks how many consecutive samples the line has held
  // ("seen", 1 on the first sample of a run or on entering a new link state).
  typedef enum int {M_ACT, M_RST, M_SUS, M_PEND, M_RWK} mst_t;
  mst_t m_st, nxt;
  logic [1:0] m_ls;
  int m_seen;
  logic m_rst_stb, m_res_stb;
  bit hold;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_st = M_ACT; m_ls = 2'b00; m_seen = 1; m_rst_stb = 0; m_res_stb = 0;
    end else begin
      nxt = m_st;
      case (m_st)
        M_ACT:
          if (m_ls == 2'b00 && m_seen == RT) nxt = M_RST;
          else if (m_ls == 2'b10 && m_seen == ST) nxt = M_SUS;
        M_RST: if (m_ls != 2'b00) nxt = M_ACT;
        M_SUS, M_PEND:
          if (m_ls == 2'b01) nxt = M_ACT;
          else if (m_ls == 2'b00 && m_seen == RT) nxt = M_RST;
          else if (m_st == M_SUS) begin if (req && ena) nxt = M_PEND; end
          else if (!ena) nxt = M_SUS;
          else if (m_ls == 2'b10 && m_seen >= IT) nxt = M_RWK;
        M_RWK: if (m_seen == WT) nxt = M_ACT;
        default: nxt = M_ACT;
      endcase
      hold = (nxt == m_st) || (m_st == M_SUS && nxt == M_PEND);
      if (!hold) m_seen = 1;
      else if (m_st == M_RWK) m_seen++;
      else if ({dp, dn} != m_ls || chg) m_seen = 1;
      else if (m_seen < (1 << CW)) m_seen++;
      m_rst_stb = (nxt == M_RST) && (m_st != M_RST);
      m_res_stb = (nxt == M_ACT) && (m_st inside {M_SUS, M_PEND, M_RWK});
      m_ls = {dp, dn};
      m_st = nxt;
    end
  end

  task automatic tick();
    @(posedge clk); @(negedge clk);
  endtask

  task automatic set_line(input logic [1:0] v);
    {dp, dn} = v;
  endtask

  task automatic test_reset();
    set_line(2'b10); pdp = 1; pdn = 0; pen = 1;
    rst = 1; #12;
    total++;
    if ({ls, br, brs, sus, res, busy} !== 7'b0) begin
      bad++; $display("FAIL reset_status got=%b exp=0", {ls, br, brs, sus, res, busy});
    end
    total++;
    if ({tdp, tdn, ten} !== {pdp, pdn, pen}) begin
      bad++; $display("FAIL reset_txmux got=%b exp=%b", {tdp, tdn, ten}, {pdp, pdn, pen});
    end
    @(negedge clk); rst = 0;
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_bus_reset();
    set_line(2'b00);
    for (int k = 1; k <= 25; k++) begin
      tick();
      total++;
      if (brs !== (k == 9) || br !== (k >= 9 && k <= 21)) begin
        bad++; $display("FAIL bus_reset k=%0d got stb=%b lvl=%b exp stb=%b lvl=%b",
                        k, brs, br, (k == 9), (k >= 9 && k <= 21));
      end
      if (k == 20) set_line(2'b10);
    end
  endtask

  task automatic test_suspend();
    pdp = 1; pdn = 0; pen = 1;
    set_line(2'b00);
    for (int k = 1; k <= 7; k++) begin
      tick();
      total++;
      if (br !== 1'b0) begin bad++; $display("FAIL short_se0 k=%0d got=%b exp=0", k, br); end
    end
    set_line(2'b10);
    for (int k = 1; k <= 70; k++) begin
      tick();
      total++;
      if (br !== 1'b0 || sus !== (k >= 65) || ten !== (k < 65)) begin
        bad++; $display("FAIL suspend k=%0d got br=%b sus=%b en=%b exp br=0 sus=%b en=%b",
                        k, br, sus, ten, (k >= 65), (k < 65));
      end
    end
  endtask

  task automatic test_resume();
    set_line(2'b01);
    for (int k = 1; k <= 3; k++) begin
      tick();
      total++;
      if (res !== (k == 2) || sus !== (k < 2) || ten !== (k >= 2) || tdp !== (k >= 2)) begin
        bad++; $display("FAIL resume k=%0d got res=%b sus=%b en=%b dp=%b exp res=%b sus=%b en=%b",
                        k, res, sus, ten, tdp, (k == 2), (k < 2), (k >= 2));
      end
    end
  endtask

  task automatic test_rwk();
    logic [2:0] etx;
    ena = 1;
    set_line(2'b10);
    for (int k = 1; k <= 65; k++) begin
      tick();
      if (k == 64 || k == 65) begin
        total++;
        if (sus !== (k == 65)) begin
          bad++; $display("FAIL rwk_susp k=%0d got=%b exp=%b", k, sus, (k == 65));
        end
      end
    end
    for (int s = 1; s <= 50; s++) begin
      tick();
      if (s < 32)       etx = 3'b000;
      else if (s < 48)  etx = 3'b011;
      else              etx = {pdp, pdn, pen};
      total++;
      if (busy !== (s >= 11 && s <= 47) || {tdp, tdn, ten} !== etx ||
          res !== (s == 48) || sus !== (s < 32)) begin
        bad++; $display("FAIL rwk s=%0d got busy=%b tx=%b res=%b sus=%b exp busy=%b tx=%b res=%b sus=%b",
                        s, busy, {tdp, tdn, ten}, res, sus, (s >= 11 && s <= 47), etx, (s == 48), (s < 32));
      end
      req = (s == 10);
    end
  endtask

  task automatic test_rwk_disabled();
    int n = 0;
    while (sus !== 1'b1 && n < 200) begin tick(); n++; end
    total++;
    if (sus !== 1'b1) begin bad++; $display("FAIL rwkdis_reach got=%b exp=1", sus); end
    for (int i = 0; i < 5; i++) tick();
    ena = 0; req = 1; tick(); req = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      total++;
      if (sus !== 1'b1 || busy !== 1'b0 || ten !== 1'b0) begin
        bad++; $display("FAIL rwk_disabled k=%0d got sus=%b busy=%b en=%b exp 1 0 0", k, sus, busy, ten);
      end
    end
    ena = 1;
  endtask

  task automatic test_async_rst();
    int n = 0;
    pen = 0; pdp = 1; pdn = 0;
    req = 1; tick(); req = 0;
    while (!(ten === 1'b1 && tdn === 1'b1) && n < 100) begin tick(); n++; end
    total++;
    if (ten !== 1'b1) begin bad++; $display("FAIL arst_reach_rwk got=%b exp=1", ten); end
    tick(); tick();
    #2 rst = 1;
    #1;
    total++;
    if ({tdp, tdn, ten} !== {pdp, pdn, pen} || {ls, br, brs, sus, res, busy} !== 7'b0) begin
      bad++; $display("FAIL async_rst got tx=%b st=%b exp tx=%b st=0",
                      {tdp, tdn, ten}, {ls, br, brs, sus, res, busy}, {pdp, pdn, pen});
    end
    @(negedge clk); rst = 0;
  endtask

  task automatic test_chg();
    set_line(2'b10);
    for (int i = 0; i < 40; i++) tick();
    chg = 1; tick(); chg = 0;
    for (int c = 1; c <= 70; c++) begin
      tick();
      total++;
      if (sus !== (c >= 64)) begin
        bad++; $display("FAIL chg_restart c=%0d got=%b exp=%b", c, sus, (c >= 64));
      end
    end
  endtask

  task automatic test_random();
    int seg = 0;
    logic [1:0] v;
    logic [10:0] exp_v, got_v;
    logic [2:0] etx;
    rst = 1; set_line(2'b10); req = 0; chg = 0; ena = 1;
    @(negedge clk); rst = 0;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      tick();
      case (m_st)
        M_ACT:   etx = {pdp, pdn, pen};
        M_RWK:   etx = 3'b011;
        default: etx = 3'b000;
      endcase
      exp_v = {m_ls, m_st == M_RST, m_rst_stb, m_st inside {M_SUS, M_PEND},
               m_res_stb, m_st inside {M_PEND, M_RWK}, etx};
      got_v = {ls, br, brs, sus, res, busy, tdp, tdn, ten};
      total++;
      if (got_v !== exp_v) begin
        bad++; $display("FAIL random cyc=%0d got=%b exp=%b", cyc, got_v, exp_v);
      end
      if (seg == 0) begin
        case ($urandom_range(0, 9))
          0, 1:    begin v = 2'b00; seg = $urandom_range(3, 12); end
          2:       begin v = 2'b01; seg = $urandom_range(1, 4); end
          3:       begin v = 2'b11; seg = $urandom_range(1, 3); end
          4, 5, 6: begin v = 2'b10; seg = $urandom_range(60, 140); end
          default: begin v = 2'b10; seg = $urandom_range(1, 20); end
        endcase
        set_line(v);
      end
      seg--;
      chg = ($urandom_range(0, 49) == 0);
      req = ($urandom_range(0, 14) == 0);
      if ($urandom_range(0, 39) == 0) ena = ~ena;
      {pdp, pdn, pen} = 3'($urandom);
    end
    req = 0; chg = 0;
  endtask

  initial begin
    test_reset();
    test_bus_reset();
    test_suspend();
    test_resume();
    test_rwk();
    test_rwk_disabled();
    test_async_rst();
    test_chg();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
